icache_refill_responder: RTL and testbench
==========================================

# icache_refill_responder

Memory-side responder for the instruction-cache line-fill handshake. It accepts a refill request (`memory_valid`, `load_addr`) from the instruction cache. It fetches the whole cache line as sequential single-word reads from a 32-bit backing memory port, assembles the line, and returns it on `inst_from_mem` with a one-cycle `memory_ready` pulse. It sits between the instruction cache and the instruction memory or bus bridge.

## Interface
- `WORD`, 32, data word width in bits.
- `CACHE_LINE_WIDTH`, 128, line width in bits; BEATS = CACHE_LINE_WIDTH/WORD = 4.
- `CACHE_LINE_BYTE_LOG`, 4, log2 of line size in bytes.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `memory_valid`  in  1  refill request from the cache, held until `memory_ready` is seen.
- `load_addr`  in  WORD  request address; the offset bits [CACHE_LINE_BYTE_LOG-1:0] are ignored.
- `memory_ready`  out  1  one-cycle pulse: `inst_from_mem` holds the requested line.
- `inst_from_mem`  out  CACHE_LINE_WIDTH  assembled line; word k at bits [WORD*k+WORD-1:WORD*k].
- `mem_rd_req`  out  1  word read request to the backing memory.
- `mem_rd_addr`  out  WORD  byte address of the word read, always 4-byte aligned.
- `mem_rd_ack`  in  1  memory accepted the request this cycle.
- `mem_rd_valid`  in  1  read data valid this cycle.
- `mem_rd_data`  in  WORD  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If `memory_valid`=1: latch base = {load_addr[WORD-1:CACHE_LINE_BYTE_LOG], 0}, set beat=0, go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - Drive `mem_rd_req`=1 and `mem_rd_addr`=base+4*beat.
  - Hold the request and address stable until `mem_rd_ack`.
  - On ack without `mem_rd_valid`, go to WAIT.
  - On ack with `mem_rd_valid` in the same cycle (zero-latency memory), capture the word immediately and apply the beat-complete rule.
- WAIT:
  - `mem_rd_req`=0.
  - On `mem_rd_valid`, capture `mem_rd_data` into line word [beat] and apply the beat-complete rule.
- Beat-complete rule: if beat = BEATS-1, go to RESP; otherwise beat = beat+1 and go to REQ.
- RESP:
  - `memory_ready`=1 for exactly one cycle, with the full line stable on `inst_from_mem`.
  - Next state is unconditionally IDLE.
- At most one word read is outstanding at any time. Words are always read in order 0..BEATS-1; there is no critical-word-first.
- `mem_rd_valid` is ignored in IDLE and RESP, and in REQ without `mem_rd_ack`.
- `memory_valid` is sampled only in IDLE. Once a refill is accepted it always completes and pulses `memory_ready`, even if `memory_valid` drops mid-refill (cache flush). The requester ignores an unwanted pulse.
- `load_addr` is sampled only on acceptance; later changes have no effect on the refill in progress.
- The line register updates one word per captured beat and holds its value between refills.

## Timing
- Reset values, applied asynchronously while `rst`=0:
  - state=IDLE, beat=0.
  - `memory_ready`=0, `mem_rd_req`=0, `mem_rd_addr`=0, `inst_from_mem`=0.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Minimum latency, with ack and valid in the same cycle as the request:
  - `memory_valid` sampled at edge 0.
  - REQ at cycles 1-4.
  - `memory_ready` high in cycle 5.
- General latency: 1 + sum over beats of (ack wait + 1 + data latency) + 1 cycles.
- Back-to-back refills: when `memory_valid` is still 1 in the IDLE cycle after RESP, it is a new request and is accepted. The requester must drop `memory_valid` in the cycle after it sees `memory_ready`.
- Address arithmetic is WORD-bit and wraps modulo 2^WORD. For example, base 0xFFFFFFF0 reads 0xFFFFFFF0..0xFFFFFFFC.
- Reset asserted mid-refill aborts immediately, with no `memory_ready`. A memory response still in flight after reset is ignored under the IDLE rule.

## Test plan
- Single refill, 0-cycle memory: `load_addr`=0x1C00_0038, `memory_valid`=1 → `mem_rd_addr` 0x1C00_0030, 34, 38, 3C in cycles 1-4; `memory_ready` pulse in cycle 5; `inst_from_mem` = {w3,w2,w1,w0}, with word 0 in bits [31:0].
- Stretched handshake, ack delayed 2 cycles and data 3 cycles after ack on every beat → `mem_rd_addr` stable while waiting; exactly 4 requests issued; exactly one `memory_ready` pulse; line correct.
- Stale data: `mem_rd_valid`=1 with 0xDEADBEEF in IDLE and in REQ without ack → no capture, line unchanged.
- Back-to-back: `memory_valid` held high through RESP with a new `load_addr` 0x0000_0100 → second refill starts the cycle after IDLE and reads 0x100..0x10C.
- Abort cases:
  - `memory_valid` dropped after beat 1 → refill completes and `memory_ready` still pulses.
  - `rst`=0 during WAIT of beat 2 → outputs go to 0 immediately; no pulse after reset release.
- Wrap: `load_addr`=0xFFFF_FFF4 → reads 0xFFFFFFF0, F4, F8, FC.

Source files
------------

// File: rtl/icache_refill_responder.sv
// Memory-side responder for instruction-cache line fills: reads the line as
// in-order single-word reads and returns it with a one-cycle ready pulse.
module icache_refill_responder #(
    parameter int WORD                = 32,
    parameter int CACHE_LINE_WIDTH    = 128,
    parameter int CACHE_LINE_BYTE_LOG = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        memory_valid,
    input  logic [WORD-1:0]             load_addr,
    output logic                        memory_ready,
    output logic [CACHE_LINE_WIDTH-1:0] inst_from_mem,
    output logic                        mem_rd_req,
    output logic [WORD-1:0]             mem_rd_addr,
    input  logic                        mem_rd_ack,
    input  logic                        mem_rd_valid,
    input  logic [WORD-1:0]             mem_rd_data
);

    localparam int BEATS = CACHE_LINE_WIDTH / WORD;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WB    = WORD / 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat;
    logic [WORD-1:0] base;

    logic [WORD-1:0] line_base;
    logic [BW-1:0]   beat_nxt;
    logic [WORD-1:0] nxt_addr;
    logic            last_beat;
    logic            capture;
    logic            unused_offset;

    // Offset bits of the request address never reach the backing memory.
    assign unused_offset = ^load_addr[CACHE_LINE_BYTE_LOG-1:0];

    assign line_base = {load_addr[WORD-1:CACHE_LINE_BYTE_LOG],
                        {CACHE_LINE_BYTE_LOG{1'b0}}};
    assign beat_nxt  = beat + 1'b1;
    assign nxt_addr  = base + (WORD'(beat_nxt) * WORD'(WB));
    assign last_beat = (beat == BW'(BEATS - 1));

    // A word is taken on same-cycle ack+data in REQ, or on data in WAIT.
    assign capture = ((state == REQ) && mem_rd_ack && mem_rd_valid) ||
                     ((state == WAIT) && mem_rd_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            beat          <= '0;
            base          <= '0;
            memory_ready  <= 1'b0;
            mem_rd_req    <= 1'b0;
            mem_rd_addr   <= '0;
            inst_from_mem <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (memory_valid) begin
                        base        <= line_base;
                        beat        <= '0;
                        mem_rd_req  <= 1'b1;
                        mem_rd_addr <= line_base;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (mem_rd_ack && !mem_rd_valid) begin
                        mem_rd_req <= 1'b0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    mem_rd_req <= 1'b0;
                end
                RESP: begin
                    memory_ready <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (capture) begin
                inst_from_mem[WORD*beat +: WORD] <= mem_rd_data;
                if (last_beat) begin
                    mem_rd_req   <= 1'b0;
                    memory_ready <= 1'b1;
                    state        <= RESP;
                end else begin
                    beat        <= beat_nxt;
                    mem_rd_req  <= 1'b1;
                    mem_rd_addr <= nxt_addr;
                    state       <= REQ;
                end
            end
        end
    end

endmodule

// File: tb/tb_icache_refill_responder.sv
// Randomized scoreboard bench for icache_refill_responder with a
// behavioural backing memory and line-level reference model.
module tb_icache_refill_responder;

    logic         clk;
    logic         rst;
    logic         memory_valid;
    logic [31:0]  load_addr;
    logic         memory_ready;
    logic [127:0] inst_from_mem;
    logic         mem_rd_req;
    logic [31:0]  mem_rd_addr;
    logic         mem_rd_ack;
    logic         mem_rd_valid;
    logic [31:0]  mem_rd_data;

    icache_refill_responder #(
        .WORD(32),
        .CACHE_LINE_WIDTH(128),
        .CACHE_LINE_BYTE_LOG(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .memory_valid(memory_valid),
        .load_addr(load_addr),
        .memory_ready(memory_ready),
        .inst_from_mem(inst_from_mem),
        .mem_rd_req(mem_rd_req),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_ack(mem_rd_ack),
        .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_acks = 0;
    int n_ready = 0;
    int ack_dly = 0;
    int dat_lat = 0;

    logic [31:0]  mem [logic [31:0]];
    logic [31:0]  exp_addr [$];
    logic [127:0] exp_line [$];
    logic [127:0] last_line = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic stale();
        if ($urandom_range(0, 2) == 0) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = 32'hDEADBEEF;
        end
    endtask

    // Backing memory: configurable ack delay and data latency per beat.
    initial begin
        logic [31:0] a;
        mem_rd_ack   = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            mem_rd_ack   = 1'b0;
            mem_rd_valid = 1'b0;
            mem_rd_data  = '0;
            if (rst && mem_rd_req) begin
                a = mem_rd_addr;
                for (int i = 0; i < ack_dly && rst; i++) begin
                    stale();
                    @(negedge clk);
                    mem_rd_valid = 1'b0;
                    mem_rd_data  = '0;
                end
                if (rst) begin
                    mem_rd_ack = 1'b1;
                    if (dat_lat == 0) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_data  = mem.exists(a) ? mem[a] : 32'hBAD00000;
                    end else begin
                        @(negedge clk);
                        mem_rd_ack = 1'b0;
                        for (int i = 1; i < dat_lat && rst; i++) @(negedge clk);
                        if (rst) begin
                            mem_rd_valid = 1'b1;
                            mem_rd_data  = mem.exists(a) ? mem[a] : 32'hBAD00000;
                        end
                    end
                end
            end else if (rst) begin
                stale();
            end
        end
    end

    // Monitor: pops expected addresses on each accepted read and
    // expected lines on each ready pulse.
    initial begin
        logic        pr, pa, prdy;
        logic [31:0] paddr;
        pr = 0; pa = 0; prdy = 0; paddr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                pr = 0; pa = 0; prdy = 0;
            end else begin
                if (pr && !pa && mem_rd_req)
                    chk("addr_stable", mem_rd_addr, paddr);
                if (mem_rd_req && mem_rd_ack) begin
                    n_acks++;
                    chk("req_expected", exp_addr.size() != 0, 1);
                    if (exp_addr.size() != 0)
                        chk("rd_addr", mem_rd_addr, exp_addr.pop_front());
                end
                if (memory_ready) begin
                    n_ready++;
                    chk("ready_one_cycle", prdy, 0);
                    chk("ready_expected", exp_line.size() != 0, 1);
                    if (exp_line.size() != 0)
                        chk("line", inst_from_mem, exp_line.pop_front());
                end
                pr    = mem_rd_req;
                pa    = mem_rd_ack;
                prdy  = memory_ready;
                paddr = mem_rd_addr;
            end
        end
    end

    task automatic issue(input logic [31:0] a);
        logic [31:0]  b, w, wa;
        logic [127:0] ln;
        b  = {a[31:4], 4'h0};
        ln = '0;
        for (int k = 0; k < 4; k++) begin
            w  = $urandom;
            wa = b + 32'(4 * k);
            mem[wa] = w;
            ln[32*k +: 32] = w;
            exp_addr.push_back(wa);
        end
        exp_line.push_back(ln);
        last_line    = ln;
        memory_valid = 1'b1;
        load_addr    = a;
    endtask

    task automatic wait_ready(input int drop_at, output int lat);
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (memory_ready) begin
                lat = n;
                return;
            end
            if (n == drop_at) memory_valid = 1'b0;
            if (n >= 2 && $urandom_range(0, 1) == 1) load_addr = $urandom;
        end
    endtask

    task automatic run(input logic [31:0] a, input int d, input int l,
                       input int drop_at, input bit chained, input bit keep);
        int lat;
        if (!chained) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            chk("line_hold", inst_from_mem, last_line);
        end
        ack_dly = d;
        dat_lat = l;
        issue(a);
        wait_ready(drop_at, lat);
        chk("latency", lat, 4 * (d + l + 1) + 1 + (chained ? 1 : 0));
        if (!keep) memory_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base_acks, base_rdy;
        bit  found, keep, nk;
        rst          = 1'b1;
        memory_valid = 1'b0;
        load_addr    = '0;
        #2;
        rst = 1'b0;
        #1;
        chk("rst_ready", memory_ready, 0);
        chk("rst_req", mem_rd_req, 0);
        chk("rst_addr", mem_rd_addr, 0);
        chk("rst_line", inst_from_mem, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run(32'h1C00_0038, 0, 0, 0, 0, 0);

        base_acks = n_acks;
        base_rdy  = n_ready;
        run($urandom, 2, 3, 0, 0, 0);
        chk("stretch_reqs", n_acks - base_acks, 4);
        chk("stretch_pulses", n_ready - base_rdy, 1);

        run($urandom, 0, 0, 0, 0, 1);
        run(32'h0000_0100, 0, 0, 0, 1, 0);

        run($urandom, 1, 1, 7, 0, 0);
        run(32'hFFFF_FFF4, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0);

        keep = 0;
        for (int i = 0; i < 25; i++) begin
            nk = (i < 24) && ($urandom_range(0, 2) == 0);
            run($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 1) == 1) ? $urandom_range(2, 20) : 0,
                keep, nk);
            keep = nk;
        end

        // Reset during the data wait of the third beat.
        repeat (2) @(negedge clk);
        ack_dly   = 1;
        dat_lat   = 3;
        base_acks = n_acks;
        base_rdy  = n_ready;
        issue($urandom);
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            #3;
            if ((n_acks - base_acks) == 3 && !mem_rd_req) found = 1;
        end
        chk("abort_reached", found, 1);
        rst = 1'b0;
        #1;
        chk("abort_ready", memory_ready, 0);
        chk("abort_req", mem_rd_req, 0);
        chk("abort_addr", mem_rd_addr, 0);
        chk("abort_line", inst_from_mem, 0);
        memory_valid = 1'b0;
        exp_addr.delete();
        exp_line.delete();
        last_line = '0;
        repeat (3) @(negedge clk);
        #3;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_pulse_after_reset", n_ready, base_rdy);

        run($urandom, 0, 2, 0, 0, 0);
        run($urandom, 3, 0, 0, 0, 0);

        repeat (10) @(negedge clk);
        chk("addr_queue_empty", exp_addr.size(), 0);
        chk("line_queue_empty", exp_line.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
